// File: rtl/ux607_ilm_init_pkg.sv
// ----------------------------------------------------------------------------
// ux607_ilm_init_pkg
// Shared types and constants for the UX607 ILM initialization controller.
//   ilm_init_state_e : controller FSM state (IDLE, CLEAR, LOAD, DONE)
//   ILM_DW           : ILM data word width in bits
//   ILM_ECC_W        : SEC-DED check-bit width
//   ILM_BYTE_LANES   : bytes packed per ILM word
//   ILM_WDATA_W      : width of the ILM write-data bus; 40 when the
//                      UX607_ILM_INIT_ECC_EN macro is defined, else 32
// ----------------------------------------------------------------------------
package ux607_ilm_init_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } ilm_init_state_e;

    localparam int ILM_ECC_W      = 7;
    localparam int ILM_DW         = 32;
    localparam int ILM_BYTE_LANES = ILM_DW / 8;

`ifdef UX607_ILM_INIT_ECC_EN
    // [31:0] data, [38:32] check bits, [39] tied low
    localparam int ILM_WDATA_W = ILM_DW + ILM_ECC_W + 1;
`else
    localparam int ILM_WDATA_W = ILM_DW;
`endif

endpackage

// File: rtl/ux607_ilm_ecc32_gen.sv
// ----------------------------------------------------------------------------
// ux607_ilm_ecc32_gen
// Combinational SEC-DED (39,32) check-bit generator.
//   data_i [31:0] : data word
//   ecc_o  [6:0]  : {p6, p5..p0}
// p0..p5 are Hamming parities: data bit i occupies the i-th non-power-of-two
// slot (starting at 3) of a 1-based codeword, and pk covers every data bit
// whose slot number has bit k set. p6 is even parity over data and p0..p5,
// giving double-error detection.
// ----------------------------------------------------------------------------
module ux607_ilm_ecc32_gen
    import ux607_ilm_init_pkg::*;
(
    input  logic [ILM_DW-1:0]    data_i,
    output logic [ILM_ECC_W-1:0] ecc_o
);

    // Codeword slot of data bit idx; power-of-two slots hold the parities.
    function automatic int data_pos(input int idx);
        int pos;
        pos = 2;
        for (int j = 0; j < ILM_DW; j++) begin
            if (j <= idx) begin
                pos = pos + 1;
                if ((pos & (pos - 1)) == 0) pos = pos + 1;
            end
        end
        return pos;
    endfunction

    logic [5:0] ham;

    always_comb begin
        ham = '0;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < ILM_DW; i++) begin
                if (((data_pos(i) >> k) & 1) != 0) ham[k] = ham[k] ^ data_i[i];
            end
        end
    end

    assign ecc_o = {^{data_i, ham}, ham};

endmodule

// File: rtl/ux607_ilm_init_ctrl.sv
// ----------------------------------------------------------------------------
// ux607_ilm_init_ctrl
// ILM initialization controller: on start, zero-fills the whole ILM, then
// packs a little-endian byte stream into 32-bit words and writes them from
// address 0 upward, holding the core off the ILM until loading completes.
//
// Build option: define UX607_ILM_INIT_ECC_EN to widen ilm_wdata to 40 bits
// with SEC-DED check bits in [38:32] ([39] = 0); otherwise ilm_wdata is the
// plain 32-bit data word and no ECC generator is built.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   start       : level, sampled in IDLE/DONE to launch a clear+load run
//   s_valid/s_ready/s_data/s_last : image byte stream. A byte transfers on a
//                 cycle where s_valid and s_ready are both high; s_valid may
//                 drop at any time, s_data/s_last matter only on a transfer,
//                 and s_last marks the final byte of the image.
//   ilm_cs/ilm_we/ilm_addr/ilm_wdata : registered ILM write port
//   core_hold   : high while clearing or loading
//   done        : high in DONE
//   ovf         : sticky, image was larger than the ILM
//   dbg_state   : current FSM state
// ----------------------------------------------------------------------------
module ux607_ilm_init_ctrl
    import ux607_ilm_init_pkg::*;
#(
    parameter int ILM_RAM_DP = 4096,
    parameter int ILM_AW     = $clog2(ILM_RAM_DP)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [7:0]             s_data,
    input  logic                   s_last,
    output logic                   ilm_cs,
    output logic                   ilm_we,
    output logic [ILM_AW-1:0]      ilm_addr,
    output logic [ILM_WDATA_W-1:0] ilm_wdata,
    output logic                   core_hold,
    output logic                   done,
    output logic                   ovf,
    output ilm_init_state_e        dbg_state
);

    localparam logic [ILM_AW-1:0] CLR_LAST  = ILM_AW'(ILM_RAM_DP - 1);
    // One past the last word: the load pointer parks here once the ILM is full.
    localparam logic [ILM_AW:0]   WADDR_END = (ILM_AW + 1)'(ILM_RAM_DP);
    localparam logic [1:0]        LANE_LAST = 2'(ILM_BYTE_LANES - 1);

    ilm_init_state_e        state_q, state_d;
    logic                   fin_q, fin_d;
    logic [1:0]             lane_q, lane_d;
    logic [ILM_DW-1:0]      word_q, word_d;
    logic [ILM_AW:0]        waddr_q, waddr_d;
    logic                   ovf_q, ovf_d;
    logic                   we_q, we_d;
    logic [ILM_AW-1:0]      addr_q, addr_d;
    logic [ILM_DW-1:0]      data_d;
    logic [ILM_WDATA_W-1:0] wdata_q, wdata_d;

    logic                   accept;
    logic                   img_full;
    logic                   word_wr;
    logic [ILM_DW-1:0]      merged;

    assign accept   = s_valid & s_ready;
    assign img_full = (waddr_q == WADDR_END);
    assign word_wr  = accept & ~img_full & ((lane_q == LANE_LAST) | s_last);

    // Accepted byte merged into its lane; upper lanes stay zero from the
    // word-register clear, which zero-pads a short final word.
    always_comb begin
        merged = word_q;
        merged[{lane_q, 3'b000} +: 8] = s_data;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // fin_q marks the cycle in which the s_last word is on the ILM port, so
    // DONE (and the fall of core_hold) lands one cycle after that write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_CLEAR;
            ST_CLEAR:         if (addr_q == CLR_LAST) state_d = ST_LOAD;
            ST_LOAD: begin
                if (fin_q)                          state_d = ST_DONE;
                else if (accept && s_last && !word_wr) state_d = ST_DONE;
            end
            default:          state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // s_ready drops during the fin_q cycle so nothing is taken after s_last.
    always_comb begin
        s_ready   = (state_q == ST_LOAD) && !fin_q;
        core_hold = (state_q == ST_CLEAR) || (state_q == ST_LOAD);
        done      = (state_q == ST_DONE);
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = wdata_q[ILM_DW-1:0];
        waddr_d = waddr_q;
        lane_d  = lane_q;
        word_d  = word_q;
        ovf_d   = ovf_q;
        fin_d   = fin_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    we_d   = 1'b1;
                    addr_d = '0;
                    data_d = '0;
                    ovf_d  = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (addr_q != CLR_LAST) begin
                    we_d   = 1'b1;
                    addr_d = addr_q + ILM_AW'(1);
                    data_d = '0;
                end else begin
                    waddr_d = '0;
                    lane_d  = '0;
                    word_d  = '0;
                    fin_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (fin_q) fin_d = 1'b0;
                if (accept) begin
                    if (img_full) begin
                        // ILM already full: drop the byte, never wrap
                        ovf_d = 1'b1;
                    end else if (word_wr) begin
                        we_d    = 1'b1;
                        addr_d  = waddr_q[ILM_AW-1:0];
                        data_d  = merged;
                        waddr_d = waddr_q + (ILM_AW + 1)'(1);
                        lane_d  = '0;
                        word_d  = '0;
                    end else begin
                        word_d = merged;
                        lane_d = lane_q + 2'd1;
                    end
                    if (s_last && word_wr) fin_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef UX607_ILM_INIT_ECC_EN
    logic [ILM_ECC_W-1:0] ecc_d;

    ux607_ilm_ecc32_gen u_ecc (
        .data_i (data_d),
        .ecc_o  (ecc_d)
    );

    assign wdata_d = {1'b0, ecc_d, data_d};
`else
    assign wdata_d = data_d;
`endif

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fin_q   <= 1'b0;
            lane_q  <= '0;
            word_q  <= '0;
            waddr_q <= '0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            fin_q   <= fin_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            waddr_q <= waddr_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign ilm_cs    = we_q;
    assign ilm_we    = we_q;
    assign ilm_addr  = addr_q;
    assign ilm_wdata = wdata_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: doc/ux607_ilm_init_ctrl.md
# ux607_ilm_init_ctrl

Synthesizable ILM initialization controller for the UX607 subsystem. After a start pulse it clears every ILM word, then loads a little-endian byte stream (the program image) into the ILM SRAM write port, generating SEC-DED check bits per 32-bit word. It holds the core off the ILM until loading completes, replacing backdoor preloading on silicon and FPGA builds.

## Interface
- `ILM_RAM_DP`, default 4096: ILM depth in 32-bit words.
- `ILM_AW`, default `$clog2(ILM_RAM_DP)`: word address width.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level; sampled in IDLE/DONE to begin a clear+load run.
- `s_valid` in 1: byte-stream valid.
- `s_ready` out 1: byte-stream ready.
- `s_data` in 8: image byte.
- `s_last` in 1: final byte of image; qualified by `s_valid & s_ready`.
- `ilm_cs` out 1: ILM chip select.
- `ilm_we` out 1: ILM write enable.
- `ilm_addr` out `ILM_AW`: word address.
- `ilm_wdata` out 40 with `UX607_ILM_INIT_ECC_EN`, else 32: `[31:0]` data, `[38:32]` ECC, `[39]` = 0.
- `core_hold` out 1: high while clearing or loading; core must not access ILM.
- `done` out 1: high in DONE.
- `ovf` out 1: sticky; image exceeded `ILM_RAM_DP*4` bytes.

## Operation
- FSM states: IDLE, CLEAR, LOAD, DONE.
- IDLE → CLEAR when `start`=1. DONE → CLEAR when `start`=1. `start` is ignored in CLEAR and LOAD.
- CLEAR: write all-zero data to addresses 0..`ILM_RAM_DP`-1, one per cycle (ECC of zero is 0). `ovf` is cleared on entry. After the last address, go to LOAD.
- LOAD: `s_ready`=1 on every cycle. Bytes pack little-endian: byte k of a word goes to `[8k+7:8k]`.
  - When the 4th byte is accepted, the word is written at the next address.
  - On `s_last`, a partial word is zero-padded in its upper bytes and written.
  - After the `s_last` word write, go to DONE.
  - Write address starts at 0 and increments once per word write.
- Overflow: bytes accepted once the address has passed `ILM_RAM_DP`-1 are dropped, with no write and no address wrap. `ovf` is set; `s_last` still ends LOAD.
- `s_last` on an empty-byte boundary (the previous word was just completed) produces no extra write.
- ECC: 7-bit SEC-DED; the bit sets are identical to the team's standard 32-bit ECC generator.
  - p0–p5 are Hamming parities.
  - p6 is the even parity over the 32 data bits and p0–p5.
- Reset mid-run: the FSM returns to IDLE, the partial word is discarded, and ILM contents are left as-is.

## Timing
- Reset values: `s_ready`=0, `ilm_cs`=0, `ilm_we`=0, `ilm_addr`=0, `ilm_wdata`=0, `core_hold`=0, `done`=0, `ovf`=0; state IDLE.
- `ilm_cs`, `ilm_we`, `ilm_addr`, and `ilm_wdata` are registered. `ilm_cs` = `ilm_we`, and they are asserted only for write cycles.
- Start to first CLEAR write: 1 cycle. CLEAR lasts exactly `ILM_RAM_DP` cycles of `ilm_we`=1.
- LOAD: a word write appears 1 cycle after the handshake of its last byte. Sustained rate is 1 byte/cycle with no stalls.
- `done` rises on the cycle after the final write. `core_hold` falls on the same edge.
- `core_hold` rises 1 cycle after `start` is sampled.

## Configuration
- `UX607_ILM_INIT_ECC_EN` defined: `ilm_wdata` is 40 bits, with ECC in `[38:32]` and `[39]`=0.
- Not defined: `ilm_wdata` is 32 bits, the ECC sub-module is not instantiated, and behavior is otherwise identical.

## Structure
- Package `ux607_ilm_init_pkg` holds:
  - the state enum;
  - `ILM_ECC_W`=7;
  - `ILM_DW`=32;
  - the byte-lane count constant.
- Sub-module `ux607_ilm_ecc32_gen`: combinational, 32-bit data in, 7-bit code out; instantiated only under the macro.
- Top level contains the FSM, byte packer, address counter, and output registers.

## Test plan
- Reset, then `start`=1 with `ILM_RAM_DP`=16 → 16 consecutive zero writes at addresses 0..15; `core_hold`=1 throughout; FSM then enters LOAD.
- Stream bytes 01 00 00 00 FF FF FF FF with `s_last` on the 8th → addr0 = 0x00000001 with ECC 0x43; addr1 = 0xFFFFFFFF with ECC 0x18; `done`=1 one cycle after the second write.
- Stream 5 bytes AA BB CC DD EE with `s_last` → addr0 = 0xDDCCBBAA; addr1 = 0x000000EE.
- `ILM_RAM_DP`=16, stream 70 bytes → exactly 16 load writes, `ovf`=1, no write to address 0 after CLEAR ends, DONE reached on `s_last`.
- Assert `rst` after 6 bytes of LOAD → all outputs return to reset values immediately; a new `start` repeats the full CLEAR.
- Build without the macro → `ilm_wdata` is 32 bits and data matches the ECC run bit-for-bit.
